// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared state encoding and default settle length for the ring oscillator frequency measurement controller
package ringosc_pkg;
  localparam int STATE_W = 3;
  localparam int SETTLE_CYC_DEF = 64;
  typedef enum logic [STATE_W-1:0] {IDLE, CLR, SETTLE, GATE, REPORT} state_t;
endpackage

// File: rtl/ringosc_sync_edge.sv
// ringosc_sync_edge: SYNC_STG-flop synchronizer plus rising-edge detect on async_in; clr masks the edge output (clk, rst, async_in, clr -> rise_pulse)
module ringosc_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic clr,
  output logic rise_pulse
);
  logic [SYNC_STG-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], async_in};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end
  assign rise_pulse = sync_q[SYNC_STG-1] & ~prev_q & ~clr;
endmodule

// File: rtl/ringosc_freq_meas_ctrl.sv
// ringosc_freq_meas_ctrl: settles the ring, counts synchronized tap edges over a win_len-cycle gate and posts res_count/res_ovf with a valid/ack handshake
import ringosc_pkg::*;
module ringosc_freq_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 20,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SYNC_STG   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ring_tap,
  output logic             ring_en,
  output logic             div_rst,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
);
  state_t state, state_nx;
  logic [WIN_W-1:0] win_q, tmr;
  logic [CNT_W-1:0] edge_cnt;
  logic ovf, rise, clr, go;
  assign clr = state == CLR;
  assign go = state == IDLE && start && !res_valid;
  assign ring_en = state == SETTLE || state == GATE;
  assign div_rst = !ring_en;
  assign busy = state != IDLE;
  ringosc_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk(clk),
    .rst(rst),
    .async_in(ring_tap),
    .clr(clr),
    .rise_pulse(rise)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = go ? CLR : IDLE;
      CLR:     state_nx = SETTLE;
      SETTLE:  state_nx = tmr == '0 ? GATE : SETTLE;
      GATE:    state_nx = tmr == '0 ? REPORT : GATE;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win_q <= '0;
      tmr <= '0;
      edge_cnt <= '0;
      ovf <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) win_q <= win_len == '0 ? WIN_W'(1) : win_len;
      if (clr) tmr <= WIN_W'(SETTLE_CYC - 1);
      else if (state == SETTLE && tmr == '0) tmr <= win_q - WIN_W'(1);
      else if (ring_en) tmr <= tmr - WIN_W'(1);
      if (clr) begin
        edge_cnt <= '0;
        ovf <= 1'b0;
      end else if (state == GATE && rise) begin
        if (&edge_cnt) ovf <= 1'b1;
        else edge_cnt <= edge_cnt + CNT_W'(1);
      end
      if (state == REPORT) begin
        res_count <= edge_cnt;
        res_ovf <= ovf;
        res_valid <= 1'b1;
      end else if (res_valid && res_ack) res_valid <= 1'b0;
    end
  end
endmodule
